// File: rtl/serial_shift_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_tx_pkg
// Shared types and helpers for the serial_shift_tx transmitter.
//   tx_state_t       : FSM state encoding (IDLE, SHIFT)
//   ST_IDLE/ST_SHIFT : legacy-compatible constants derived from tx_state_t
//   even_parity()    : XOR reduction of a word (words up to 64 bits)
// -----------------------------------------------------------------------------
package serial_tx_pkg;

    typedef enum logic {IDLE, SHIFT} tx_state_t;

    localparam logic [0:0] ST_IDLE  = 1'(IDLE);
    localparam logic [0:0] ST_SHIFT = 1'(SHIFT);

    // Even parity bit: makes the total number of ones (word + bit) even.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/serial_shift_tx_if.sv
// -----------------------------------------------------------------------------
// serial_shift_tx_if
// Load handshake and serial-side status bundle of the transmitter.
//   load, data_in : request and parallel word (master -> slave)
//   ready         : transmitter idle, load accepted when load && ready
//   tx            : registered serial output
//   busy, finish  : frame in progress / one-cycle end-of-frame pulse
//   count         : index of the bit currently on tx
//   sender        : live shift-register contents
// Modports: master (datapath side), slave (transmitter side).
// -----------------------------------------------------------------------------
interface serial_shift_tx_if #(
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic              load;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              tx;
    logic              busy;
    logic              finish;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] sender;

    modport master (
        output load, data_in,
        input  ready, tx, busy, finish, count, sender
    );

    modport slave (
        input  load, data_in,
        output ready, tx, busy, finish, count, sender
    );

endinterface

// File: rtl/serial_shift_tx_bit_tick_gen.sv
// -----------------------------------------------------------------------------
// bit_tick_gen
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset
//   restart : realigns the period so the next cycle is cycle 0
//   tick    : high on the last cycle of each bit period
// With CLKS_PER_BIT=1 tick is permanently high.
// -----------------------------------------------------------------------------
module bit_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [TW-1:0] r_cnt;

    assign tick = (r_cnt == TW'(CLKS_PER_BIT - 1));

    // Period counter; wraps on tick so bit periods follow back to back.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/serial_shift_tx.sv
// -----------------------------------------------------------------------------
// serial_shift_tx
// Parallel-in/serial-out transmitter. Latches a word on load && ready and
// shifts it onto tx one bit per CLKS_PER_BIT clocks, LSB- or MSB-first,
// pulsing finish for one cycle when the frame ends.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset (overrides load)
//   bus   : serial_shift_tx_if.slave (load, data_in, ready, tx, busy,
//           finish, count, sender)
// Build option: SERIAL_SHIFT_TX_PARITY_EN appends one even-parity bit after
// the last data bit (frame becomes DATA_W+1 bits).
// -----------------------------------------------------------------------------
module serial_shift_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned MSB_FIRST    = 0,
    parameter logic        IDLE_LEVEL   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    serial_shift_tx_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
`ifdef SERIAL_SHIFT_TX_PARITY_EN
    localparam int unsigned LAST_IDX = DATA_W;
`else
    localparam int unsigned LAST_IDX = DATA_W - 1;
`endif

    logic [0:0]        r_state, w_state_nxt;
    logic [DATA_W-1:0] r_sender, w_sender_nxt;
    logic              r_tx, w_tx_nxt;
    logic [CNT_W-1:0]  r_count, w_count_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_finish, w_finish_nxt;
    logic              w_restart;
    logic              w_tick;
    logic              w_first_bit;
    logic              w_shift_bit;
    logic              w_next_bit;
    logic [DATA_W-1:0] w_shifted;
`ifdef SERIAL_SHIFT_TX_PARITY_EN
    logic              r_par, w_par_nxt;
`endif

    bit_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // Output end of the register depends on bit order; shifting is zero-filled.
    assign w_first_bit = (MSB_FIRST != 0) ? bus.data_in[DATA_W-1] : bus.data_in[0];
    assign w_shift_bit = (MSB_FIRST != 0) ? r_sender[DATA_W-2] : r_sender[1];
    assign w_shifted   = (MSB_FIRST != 0) ? {r_sender[DATA_W-2:0], 1'b0}
                                          : {1'b0, r_sender[DATA_W-1:1]};

`ifdef SERIAL_SHIFT_TX_PARITY_EN
    // After the last data bit the captured parity takes the output slot.
    assign w_next_bit = (r_count == CNT_W'(DATA_W - 1)) ? r_par : w_shift_bit;
`else
    assign w_next_bit = w_shift_bit;
`endif

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_sender_nxt = r_sender;
        w_tx_nxt     = r_tx;
        w_count_nxt  = r_count;
        w_busy_nxt   = r_busy;
        w_finish_nxt = 1'b0;
        w_restart    = 1'b0;
`ifdef SERIAL_SHIFT_TX_PARITY_EN
        w_par_nxt    = r_par;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.load) begin
                    w_state_nxt  = ST_SHIFT;
                    w_sender_nxt = bus.data_in;
                    w_tx_nxt     = w_first_bit;
                    w_count_nxt  = '0;
                    w_busy_nxt   = 1'b1;
                    w_restart    = 1'b1;
`ifdef SERIAL_SHIFT_TX_PARITY_EN
                    w_par_nxt    = even_parity(64'(bus.data_in));
`endif
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    if (r_count == CNT_W'(LAST_IDX)) begin
                        w_state_nxt  = ST_IDLE;
                        w_sender_nxt = '0;
                        w_tx_nxt     = IDLE_LEVEL;
                        w_count_nxt  = '0;
                        w_busy_nxt   = 1'b0;
                        w_finish_nxt = 1'b1;
                    end else begin
                        w_sender_nxt = w_shifted;
                        w_tx_nxt     = w_next_bit;
                        w_count_nxt  = r_count + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_sender <= '0;
            r_tx     <= IDLE_LEVEL;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
`ifdef SERIAL_SHIFT_TX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_sender <= w_sender_nxt;
            r_tx     <= w_tx_nxt;
            r_count  <= w_count_nxt;
            r_busy   <= w_busy_nxt;
            r_finish <= w_finish_nxt;
`ifdef SERIAL_SHIFT_TX_PARITY_EN
            r_par    <= w_par_nxt;
`endif
        end
    end

    assign bus.ready  = (r_state == ST_IDLE);
    assign bus.tx     = r_tx;
    assign bus.busy   = r_busy;
    assign bus.finish = r_finish;
    assign bus.count  = r_count;
    assign bus.sender = r_sender;

endmodule

// File: tb/tb_serial_shift_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_shift_tx
// Directed bench for serial_shift_tx with four configurations:
//   u4l : DATA_W=4, C=1, LSB-first      u4m : DATA_W=4, C=1, MSB-first
//   u8s : DATA_W=8, C=3, LSB-first      u8f : DATA_W=8, C=1, LSB-first
// Expected tx sequences are hand-computed tables, bit k = tx in cycle k, with
// the top entry holding the parity bit used when SERIAL_SHIFT_TX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_serial_shift_tx;

`ifdef SERIAL_SHIFT_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst_4l, rst_4m, rst_8s, rst_8f;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_shift_tx_if #(.DATA_W(4)) if4l ();
    serial_shift_tx_if #(.DATA_W(4)) if4m ();
    serial_shift_tx_if #(.DATA_W(8)) if8s ();
    serial_shift_tx_if #(.DATA_W(8)) if8f ();

    serial_shift_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .MSB_FIRST(0), .IDLE_LEVEL(1'b1))
        u4l (.clk(clk), .reset(rst_4l), .bus(if4l));
    serial_shift_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .MSB_FIRST(1), .IDLE_LEVEL(1'b1))
        u4m (.clk(clk), .reset(rst_4m), .bus(if4m));
    serial_shift_tx #(.DATA_W(8), .CLKS_PER_BIT(3), .MSB_FIRST(0), .IDLE_LEVEL(1'b1))
        u8s (.clk(clk), .reset(rst_8s), .bus(if8s));
    serial_shift_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .MSB_FIRST(0), .IDLE_LEVEL(1'b1))
        u8f (.clk(clk), .reset(rst_8f), .bus(if8f));

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_4l = 1'b1; rst_4m = 1'b1; rst_8s = 1'b1; rst_8f = 1'b1;
        if4l.load = 1'b1; if4l.data_in = 4'hF;
        if4m.load = 1'b0; if4m.data_in = 4'h0;
        if8s.load = 1'b0; if8s.data_in = 8'h00;
        if8f.load = 1'b0; if8f.data_in = 8'h00;
        step(); step();
        n_vec++; if (if4l.tx !== 1'b1)     begin n_err++; $display("FAIL reset_tx got %b want 1", if4l.tx); end
        n_vec++; if (if4l.busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy got %b want 0", if4l.busy); end
        n_vec++; if (if4l.finish !== 1'b0) begin n_err++; $display("FAIL reset_finish got %b want 0", if4l.finish); end
        n_vec++; if (if4l.count !== 3'd0)  begin n_err++; $display("FAIL reset_count got %0d want 0", if4l.count); end
        n_vec++; if (if4l.sender !== 4'h0) begin n_err++; $display("FAIL reset_sender got %h want 0", if4l.sender); end
        n_vec++; if (if4l.ready !== 1'b1)  begin n_err++; $display("FAIL reset_ready got %b want 1", if4l.ready); end
        n_vec++; if (if8s.tx !== 1'b1)     begin n_err++; $display("FAIL reset_tx_8s got %b want 1", if8s.tx); end
        if4l.load = 1'b0;
        rst_4l = 1'b0; rst_4m = 1'b0; rst_8s = 1'b0; rst_8f = 1'b0;
        step();
        n_vec++; if (if4l.busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got %b want 0", if4l.busy); end
    endtask

    task automatic test_lsb4();
        logic [4:0] exp_tx = 5'b0_0101;
        if4l.data_in = 4'b0101; if4l.load = 1'b1;
        step();
        if4l.load = 1'b0; if4l.data_in = 4'b1111;
        n_vec++; if (if4l.sender !== 4'b0101) begin n_err++; $display("FAIL lsb4_sender0 got %b want 0101", if4l.sender); end
        for (int k = 0; k < 4 + PAR; k++) begin
            n_vec++; if (if4l.tx !== exp_tx[k]) begin n_err++; $display("FAIL lsb4_tx[%0d] got %b want %b", k, if4l.tx, exp_tx[k]); end
            n_vec++; if (if4l.count !== 3'(k)) begin n_err++; $display("FAIL lsb4_count[%0d] got %0d want %0d", k, if4l.count, k); end
            n_vec++; if (if4l.finish !== 1'b0 || if4l.ready !== 1'b0) begin n_err++; $display("FAIL lsb4_fin_rdy[%0d] got %b%b want 00", k, if4l.finish, if4l.ready); end
            if (k == 1) begin
                n_vec++; if (if4l.sender !== 4'b0010) begin n_err++; $display("FAIL lsb4_sender1 got %b want 0010", if4l.sender); end
            end
            step();
        end
        n_vec++; if (if4l.finish !== 1'b1) begin n_err++; $display("FAIL lsb4_finish got %b want 1", if4l.finish); end
        n_vec++; if (if4l.tx !== 1'b1 || if4l.busy !== 1'b0 || if4l.count !== 3'd0 || if4l.sender !== 4'h0)
            begin n_err++; $display("FAIL lsb4_end got tx=%b busy=%b cnt=%0d snd=%h want 1 0 0 0", if4l.tx, if4l.busy, if4l.count, if4l.sender); end
        step();
        n_vec++; if (if4l.finish !== 1'b0 || if4l.tx !== 1'b1) begin n_err++; $display("FAIL lsb4_after got fin=%b tx=%b want 0 1", if4l.finish, if4l.tx); end
    endtask

    task automatic test_msb4();
        logic [4:0] exp_tx = 5'b0_1010;
        if4m.data_in = 4'b0101; if4m.load = 1'b1;
        step();
        if4m.load = 1'b0;
        for (int k = 0; k < 4 + PAR; k++) begin
            n_vec++; if (if4m.tx !== exp_tx[k]) begin n_err++; $display("FAIL msb4_tx[%0d] got %b want %b", k, if4m.tx, exp_tx[k]); end
            if (k == 1) begin
                n_vec++; if (if4m.sender !== 4'b1010) begin n_err++; $display("FAIL msb4_sender1 got %b want 1010", if4m.sender); end
            end
            step();
        end
        n_vec++; if (if4m.finish !== 1'b1 || if4m.sender !== 4'h0) begin n_err++; $display("FAIL msb4_end got fin=%b snd=%b want 1 0000", if4m.finish, if4m.sender); end
    endtask

    task automatic test_slow8_ignore_load();
        logic [8:0] exp_tx = 9'b0_1010_0101;
        if8s.data_in = 8'hA5; if8s.load = 1'b1;
        step();
        if8s.load = 1'b0; if8s.data_in = 8'h00;
        for (int c = 0; c < (8 + PAR) * 3; c++) begin
            n_vec++; if (if8s.tx !== exp_tx[c / 3]) begin n_err++; $display("FAIL slow8_tx[%0d] got %b want %b", c, if8s.tx, exp_tx[c / 3]); end
            n_vec++; if (if8s.count !== 4'(c / 3)) begin n_err++; $display("FAIL slow8_count[%0d] got %0d want %0d", c, if8s.count, c / 3); end
            n_vec++; if (if8s.busy !== 1'b1 || if8s.finish !== 1'b0) begin n_err++; $display("FAIL slow8_busy[%0d] got %b%b want 10", c, if8s.busy, if8s.finish); end
            if (c == 9) begin if8s.load = 1'b1; if8s.data_in = 8'hFF; end
            if (c == 10) begin if8s.load = 1'b0; if8s.data_in = 8'h00; end
            step();
        end
        n_vec++; if (if8s.finish !== 1'b1 || if8s.busy !== 1'b0 || if8s.tx !== 1'b1)
            begin n_err++; $display("FAIL slow8_end got fin=%b busy=%b tx=%b want 1 0 1", if8s.finish, if8s.busy, if8s.tx); end
        step();
        n_vec++; if (if8s.finish !== 1'b0) begin n_err++; $display("FAIL slow8_pulse got %b want 0", if8s.finish); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_a = 9'b1_0000_0001;
        logic [8:0] exp_b = 9'b1_1000_0000;
        if8f.data_in = 8'h01; if8f.load = 1'b1;
        step();
        if8f.data_in = 8'h80;
        for (int k = 0; k < 8 + PAR; k++) begin
            n_vec++; if (if8f.tx !== exp_a[k]) begin n_err++; $display("FAIL b2b_a_tx[%0d] got %b want %b", k, if8f.tx, exp_a[k]); end
            step();
        end
        n_vec++; if (if8f.finish !== 1'b1 || if8f.tx !== 1'b1 || if8f.ready !== 1'b1)
            begin n_err++; $display("FAIL b2b_gap got fin=%b tx=%b rdy=%b want 1 1 1", if8f.finish, if8f.tx, if8f.ready); end
        step();
        if8f.load = 1'b0;
        n_vec++; if (if8f.busy !== 1'b1 || if8f.finish !== 1'b0 || if8f.count !== 4'd0)
            begin n_err++; $display("FAIL b2b_restart got busy=%b fin=%b cnt=%0d want 1 0 0", if8f.busy, if8f.finish, if8f.count); end
        for (int k = 0; k < 8 + PAR; k++) begin
            n_vec++; if (if8f.tx !== exp_b[k]) begin n_err++; $display("FAIL b2b_b_tx[%0d] got %b want %b", k, if8f.tx, exp_b[k]); end
            step();
        end
        n_vec++; if (if8f.finish !== 1'b1) begin n_err++; $display("FAIL b2b_b_finish got %b want 1", if8f.finish); end
        step();
    endtask

    task automatic test_reset_mid_frame();
        logic seen_fin = 1'b0;
        if8f.data_in = 8'h00; if8f.load = 1'b1;
        step();
        if8f.load = 1'b0;
        for (int k = 0; k < 4; k++) step();
        n_vec++; if (if8f.count !== 4'd4 || if8f.tx !== 1'b0) begin n_err++; $display("FAIL midrst_pre got cnt=%0d tx=%b want 4 0", if8f.count, if8f.tx); end
        rst_8f = 1'b1;
        step();
        rst_8f = 1'b0;
        n_vec++; if (if8f.tx !== 1'b1 || if8f.busy !== 1'b0 || if8f.count !== 4'd0 || if8f.sender !== 8'h00 || if8f.ready !== 1'b1)
            begin n_err++; $display("FAIL midrst_state got tx=%b busy=%b cnt=%0d snd=%h rdy=%b want 1 0 0 00 1", if8f.tx, if8f.busy, if8f.count, if8f.sender, if8f.ready); end
        for (int k = 0; k < 10; k++) begin
            if (if8f.finish === 1'b1) seen_fin = 1'b1;
            step();
        end
        n_vec++; if (seen_fin !== 1'b0) begin n_err++; $display("FAIL midrst_finish got %b want 0", seen_fin); end
    endtask

    task automatic test_parity();
        logic [4:0] exp_tx = 5'b1_0111;
        if4l.data_in = 4'b0111; if4l.load = 1'b1;
        step();
        if4l.load = 1'b0;
        for (int k = 0; k < 4 + PAR; k++) begin
            n_vec++; if (if4l.tx !== exp_tx[k]) begin n_err++; $display("FAIL par_tx[%0d] got %b want %b", k, if4l.tx, exp_tx[k]); end
            n_vec++; if (if4l.count !== 3'(k)) begin n_err++; $display("FAIL par_count[%0d] got %0d want %0d", k, if4l.count, k); end
            step();
        end
        n_vec++; if (if4l.finish !== 1'b1 || if4l.tx !== 1'b1) begin n_err++; $display("FAIL par_finish got fin=%b tx=%b want 1 1", if4l.finish, if4l.tx); end
        step();
    endtask

    initial begin
        test_reset();
        test_lsb4();
        test_msb4();
        test_slow8_ignore_load();
        test_back_to_back();
        test_reset_mid_frame();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
